// File: rtl/fsub_pipe_if.sv
// rtl/fsub_pipe_if.sv - operand/result handshake bundle for the pipelined subtractor
interface fsub_pipe_if #(parameter int TAG_W = 5);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      x1;
  logic [31:0]      x2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      y;
  logic [TAG_W-1:0] out_tag;
  logic             ovf;

  modport master (
    output in_valid, x1, x2, in_tag, out_ready,
    input  in_ready, out_valid, y, out_tag, ovf
  );

  modport slave (
    input  in_valid, x1, x2, in_tag, out_ready,
    output in_ready, out_valid, y, out_tag, ovf
  );
endinterface

// File: rtl/fsub_pipe.sv
// rtl/fsub_pipe.sv - three-stage pipelined single-precision subtractor y = x1 - x2
module fsub_pipe #(
  parameter int TAG_W = 5
) (
  input logic        clk,
  input logic        rst,
  fsub_pipe_if.slave bus
);

  // stage valids and handshake-driven load enables
  logic s1_v, s2_v, s3_v;
  logic load1, load2, load3;

  assign load3 = !s3_v || bus.out_ready;
  assign load2 = !s2_v || load3;
  assign load1 = !s1_v || load2;
  assign bus.in_ready = load1;

  // ---------------- S1: align ----------------
  logic        sa, sb, a_big, sl;
  logic [7:0]  ea, eb, el, es, diff;
  logic [24:0] ma, mb, ml, msm;
  logic [4:0]  de;
  logic [26:0] mi_al;

  // pick the larger operand and right-shift the smaller into a 27-bit field
  always_comb begin
    sa    = bus.x1[31];
    sb    = ~bus.x2[31];
    ea    = (bus.x1[30:23] == 8'd0) ? 8'd1 : bus.x1[30:23];
    eb    = (bus.x2[30:23] == 8'd0) ? 8'd1 : bus.x2[30:23];
    ma    = (bus.x1[30:23] == 8'd0) ? 25'd0 : {2'b01, bus.x1[22:0]};
    mb    = (bus.x2[30:23] == 8'd0) ? 25'd0 : {2'b01, bus.x2[22:0]};
    a_big = (ea > eb) || ((ea == eb) && (ma >= mb));
    el    = a_big ? ea : eb;
    es    = a_big ? eb : ea;
    ml    = a_big ? ma : mb;
    msm   = a_big ? mb : ma;
    sl    = a_big ? sa : sb;
    diff  = el - es;
    de    = (diff > 8'd31) ? 5'd31 : diff[4:0];
    mi_al = {msm, 2'b00} >> de;
  end

  logic             s1_sign, s1_sub;
  logic [7:0]       s1_exp;
  logic [24:0]      s1_ml;
  logic [26:0]      s1_mi;
  logic [TAG_W-1:0] s1_tag;

  // S1 register: capture aligned operands when the stage may advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_sign <= 1'b0;
      s1_sub  <= 1'b0;
      s1_exp  <= 8'd0;
      s1_ml   <= 25'd0;
      s1_mi   <= 27'd0;
      s1_tag  <= '0;
    end else if (load1) begin
      s1_v    <= bus.in_valid;
      s1_sign <= sl;
      s1_sub  <= sa ^ sb;
      s1_exp  <= el;
      s1_ml   <= ml;
      s1_mi   <= mi_al;
      s1_tag  <= bus.in_tag;
    end
  end

  // ---------------- S2: add/sub ----------------
  logic             s2_sign;
  logic [7:0]       s2_exp;
  logic [26:0]      s2_sum;
  logic [TAG_W-1:0] s2_tag;

  // S2 register: magnitude add or subtract; larger operand first so never negative
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v    <= 1'b0;
      s2_sign <= 1'b0;
      s2_exp  <= 8'd0;
      s2_sum  <= 27'd0;
      s2_tag  <= '0;
    end else if (load2) begin
      s2_v    <= s1_v;
      s2_sign <= s1_sign;
      s2_exp  <= s1_exp;
      s2_sum  <= s1_sub ? ({s1_ml, 2'b00} - s1_mi) : ({s1_ml, 2'b00} + s1_mi);
      s2_tag  <= s1_tag;
    end
  end

  // ---------------- S3: normalize/pack ----------------
  logic [4:0]  se;
  logic [8:0]  e9;
  logic [26:0] norm;
  logic [31:0] y_n;
  logic        ovf_n;
  logic        unused_bits;

  // leading-one normalization, underflow flush, overflow to infinity, truncation
  always_comb begin
    se = 5'd26;
    for (int i = 0; i < 26; i++) begin
      if (s2_sum[i]) se = 5'(25 - i);
    end
    e9    = {1'b0, s2_exp};
    norm  = s2_sum;
    y_n   = 32'd0;
    ovf_n = 1'b0;
    if (s2_sum[26]) begin
      norm = s2_sum >> 1;
      e9   = e9 + 9'd1;
    end else if (e9 <= {4'd0, se}) begin
      norm = s2_sum << (e9 - 9'd1);
      e9   = 9'd0;
    end else begin
      norm = s2_sum << se;
      e9   = e9 - {4'd0, se};
    end
    if (s2_sum == 27'd0) begin
      y_n = 32'd0;
    end else if (e9 >= 9'd255) begin
      y_n   = {s2_sign, 8'hFF, 23'd0};
      ovf_n = 1'b1;
    end else begin
      y_n = {s2_sign, e9[7:0], norm[24:2]};
    end
  end

  assign unused_bits = ^{norm[26:25], norm[1:0]};

  logic [31:0]      y_r;
  logic [TAG_W-1:0] tag_r;
  logic             ovf_r;

  // S3 register doubles as the output holding register during backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_v  <= 1'b0;
      y_r   <= 32'd0;
      tag_r <= '0;
      ovf_r <= 1'b0;
    end else if (load3) begin
      s3_v  <= s2_v;
      y_r   <= y_n;
      tag_r <= s2_tag;
      ovf_r <= ovf_n;
    end
  end

  assign bus.out_valid = s3_v;
  assign bus.y         = y_r;
  assign bus.out_tag   = tag_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_fsub_pipe.sv
// tb/tb_fsub_pipe.sv - self-checking bench for fsub_pipe
module tb_fsub_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;

  fsub_pipe_if #(.TAG_W(5)) bus();

  fsub_pipe #(.TAG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] y;
    logic [4:0]  tag;
    logic        ovf;
  } res_t;

  res_t expq[$];

  // reference: value-level subtraction with the block's truncation/flush rules
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic o);
    longint ea, eb, ma, mb, el, es, ml, msm, de, sm, s, e, t;
    longint se;
    logic sa, sb, sl;
    sa = a[31];
    sb = ~b[31];
    ea = (a[30:23] == 8'd0) ? 64'd1 : longint'(a[30:23]);
    eb = (b[30:23] == 8'd0) ? 64'd1 : longint'(b[30:23]);
    ma = (a[30:23] == 8'd0) ? 64'd0 : 64'h800000 + longint'(a[22:0]);
    mb = (b[30:23] == 8'd0) ? 64'd0 : 64'h800000 + longint'(b[22:0]);
    if (ea > eb || (ea == eb && ma >= mb)) begin
      el = ea; ml = ma; sl = sa; es = eb; msm = mb;
    end else begin
      el = eb; ml = mb; sl = sb; es = ea; msm = ma;
    end
    de = el - es;
    if (de > 31) de = 31;
    sm = (msm * 4) >> de;
    s  = (sa == sb) ? ml * 4 + sm : ml * 4 - sm;
    o  = 1'b0;
    r  = 32'd0;
    if (s == 0) return;
    e = el;
    if (s >= (64'd1 << 26)) begin
      s = s >> 1;
      e = e + 1;
    end else begin
      se = 0;
      t  = s;
      while (t < (64'd1 << 25)) begin
        t  = t * 2;
        se = se + 1;
      end
      if (e <= se) begin
        s = s << (e - 1);
        e = 0;
      end else begin
        s = s << se;
        e = e - se;
      end
    end
    if (e >= 255) begin
      r = {sl, 8'hFF, 23'd0};
      o = 1'b1;
    end else begin
      r = {sl, 8'(e), 23'(s >> 2)};
    end
  endfunction

  function automatic logic [31:0] rand_x2(input logic [31:0] x1);
    logic [31:0] x2;
    x2 = $urandom;
    case ($urandom_range(0, 5))
      0: x2 = {1'($urandom_range(0, 1)), x1[30:23], x2[22:0]};
      1: x2 = x1 ^ 32'($urandom_range(0, 7));
      2: x2 = x1 ^ 32'h8000_0000;
      3: x2 = {x2[31], x1[30:23] - 8'($urandom_range(0, 30)), x2[22:0]};
      4: x2 = x1;
      default: ;
    endcase
    return x2;
  endfunction

  function automatic logic [31:0] rand_x1();
    logic [31:0] x;
    x = $urandom;
    if ($urandom_range(0, 9) == 0) x[30:23] = 8'd0;
    return x;
  endfunction

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.x1        = 32'd0;
    bus.x2        = 32'd0;
    bus.in_tag    = 5'd0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.y !== 32'd0 || bus.out_tag !== 5'd0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b y=%h tag=%0d ovf=%b, want 0/00000000/0/0",
               bus.out_valid, bus.y, bus.out_tag, bus.ovf);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vx1 [7] = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                             32'h3F800000, 32'h7F7FFFFF, 32'h7F7FFFFF};
    logic [31:0] vx2 [7] = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h33800000,
                             32'h30800000, 32'hFF7FFFFF, 32'h7F7FFFFF};
    logic [31:0] vy  [7] = '{32'h40000000, 32'h00000000, 32'h40000000, 32'h3F7FFFFF,
                             32'h3F800000, 32'h7F800000, 32'h00000000};
    logic        vo  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [4:0]  tag;
    for (int i = 0; i < 7; i++) begin
      tag = 5'(i + 3);
      @(negedge clk);
      bus.x1 = vx1[i];
      bus.x2 = vx2[i];
      bus.in_tag = tag;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_in_ready: got %b want 1", i, bus.in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_early: out_valid=%b want 0 two edges after accept", i, bus.out_valid);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.y !== vy[i] || bus.out_tag !== tag || bus.ovf !== vo[i]) begin
        errors++;
        $display("FAIL dir%0d_result: got valid=%b y=%h tag=%0d ovf=%b, want 1/%h/%0d/%b",
                 i, bus.out_valid, bus.y, bus.out_tag, bus.ovf, vy[i], tag, vo[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] ax1 [4];
    logic [31:0] ax2 [4];
    logic [31:0] ey  [4];
    logic        eo  [4];
    for (int k = 0; k < 4; k++) begin
      ax1[k] = rand_x1();
      ax2[k] = rand_x2(ax1[k]);
      model(ax1[k], ax2[k], ey[k], eo[k]);
    end
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.x1 = ax1[k]; bus.x2 = ax2[k]; bus.in_tag = 5'(k); bus.in_valid = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_accept%0d: in_ready=%b want 1", k, bus.in_ready);
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus.x1 = ax1[3]; bus.x2 = ax2[3]; bus.in_tag = 5'd3; bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: in_ready=%b want 0", bus.in_ready);
    end
    for (int h = 0; h < 3; h++) begin
      if (h > 0) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd0 || bus.y !== ey[0] || bus.ovf !== eo[0]) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b tag=%0d y=%h ovf=%b, want 1/0/%h/%b",
                 h, bus.out_valid, bus.out_tag, bus.y, bus.ovf, ey[0], eo[0]);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_tag !== 5'd0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b tag=%0d, want 1/0", bus.in_ready, bus.out_tag);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int j = 1; j < 4; j++) begin
      if (j > 1) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'(j) || bus.y !== ey[j] || bus.ovf !== eo[j]) begin
        errors++;
        $display("FAIL bp_drain%0d: got valid=%b tag=%0d y=%h ovf=%b, want 1/%0d/%h/%b",
                 j, bus.out_valid, bus.out_tag, bus.y, bus.ovf, j, ey[j], eo[j]);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_stream();
    int sent = 0;
    int got = 0;
    bit seen = 0;
    bit acc;
    res_t r;
    expq.delete();
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
      @(negedge clk);
      if (sent < 10) begin
        bus.x1 = rand_x1();
        bus.x2 = rand_x2(bus.x1);
        bus.in_tag = 5'($urandom_range(0, 31));
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (seen) begin
        checks++;
        if (bus.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stream_bubble: out_valid=%b want 1 after %0d results", bus.out_valid, got);
        end
      end
      if (bus.out_valid === 1'b1 && expq.size() > 0) begin
        seen = 1;
        r = expq.pop_front();
        got++;
        checks++;
        if (bus.y !== r.y || bus.out_tag !== r.tag || bus.ovf !== r.ovf) begin
          errors++;
          $display("FAIL stream_result%0d: got y=%h tag=%0d ovf=%b, want %h/%0d/%b",
                   got, bus.y, bus.out_tag, bus.ovf, r.y, r.tag, r.ovf);
        end
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
        model(bus.x1, bus.x2, r.y, r.ovf);
        r.tag = bus.in_tag;
        expq.push_back(r);
        sent++;
      end
      @(posedge clk);
    end
    checks++;
    if (got != 10) begin
      errors++;
      $display("FAIL stream_count: got %0d results want 10", got);
    end
  endtask

  task automatic test_random();
    int sent = 0;
    int got = 0;
    res_t r;
    logic exp_ready;
    expq.delete();
    for (int cyc = 0; cyc < 600 && got < 80; cyc++) begin
      @(negedge clk);
      bus.in_valid = (sent < 80) && ($urandom_range(0, 9) < 7);
      bus.x1 = rand_x1();
      bus.x2 = rand_x2(bus.x1);
      bus.in_tag = 5'($urandom_range(0, 31));
      bus.out_ready = ($urandom_range(0, 9) < 6);
      #1;
      exp_ready = !(expq.size() == 3 && !bus.out_ready);
      checks++;
      if (bus.in_ready !== exp_ready) begin
        errors++;
        $display("FAIL rand_in_ready: got %b want %b (in flight %0d)", bus.in_ready, exp_ready, expq.size());
      end
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious: out_valid=1 with nothing in flight");
        end else begin
          r = expq[0];
          if (bus.y !== r.y || bus.out_tag !== r.tag || bus.ovf !== r.ovf) begin
            errors++;
            $display("FAIL rand_result: got y=%h tag=%0d ovf=%b, want %h/%0d/%b",
                     bus.y, bus.out_tag, bus.ovf, r.y, r.tag, r.ovf);
          end
          if (bus.out_ready) begin
            void'(expq.pop_front());
            got++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        model(bus.x1, bus.x2, r.y, r.ovf);
        r.tag = bus.in_tag;
        expq.push_back(r);
        sent++;
      end
      @(posedge clk);
    end
    checks++;
    if (got != 80) begin
      errors++;
      $display("FAIL rand_count: got %0d results want 80", got);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.x1 = rand_x1();
      bus.x2 = rand_x2(bus.x1);
      bus.in_tag = 5'(k);
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.y !== 32'd0 || bus.out_tag !== 5'd0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: got valid=%b y=%h tag=%0d ovf=%b, want 0/00000000/0/0",
               bus.out_valid, bus.y, bus.out_tag, bus.ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_stale%0d: out_valid=%b want 0", c, bus.out_valid);
      end
    end
    bus.x1 = 32'h40400000;
    bus.x2 = 32'h3F800000;
    bus.in_tag = 5'd9;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_early: out_valid=%b want 0", bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.y !== 32'h40000000 || bus.out_tag !== 5'd9) begin
      errors++;
      $display("FAIL midrst_after: got valid=%b y=%h tag=%0d, want 1/40000000/9",
               bus.out_valid, bus.y, bus.out_tag);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_stream();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsub_pipe.md
Name: fsub_pipe

Overview:
- Pipelined IEEE-754 single-precision subtractor, y = x1 - x2. It is the subtract-direction companion to the existing single-cycle adder in the FPU.
- Three internal stages: align, add/sub, normalize/pack. A valid/ready handshake on both sides lets the core issue one op per cycle and stall on backpressure.
- A tag field travels with each operation so the core can match results to destination registers.

Parameters:
- TAG_W, 5, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands and tag presented
- in_ready  out  1  block accepts the op this cycle
- x1  in  32  minuend
- x2  in  32  subtrahend
- in_tag  in  TAG_W  tag for this op
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts the result
- y  out  32  result
- out_tag  out  TAG_W  tag of the presented result
- ovf  out  1  result overflowed to infinity; valid only with out_valid

Behaviour:
- Reset (async, active-high): all stage valid bits clear; out_valid=0, y=0, out_tag=0, ovf=0. in_ready=1 on the first cycle after release. An op in flight when reset asserts is discarded; no partial result appears.
- Accept when in_valid&&in_ready at a rising edge. Result leaves when out_valid&&out_ready.
- Latency: exactly 3 cycles from accept to out_valid with no stalls. Throughput 1 op/cycle.
- Stall rule: each stage register loads when it is empty, or when its downstream stage loads or drains in the same cycle.
- in_ready = !(s1_v && s2_v && s3_v && !out_ready).
- A full pipe with out_ready=1 accepts and drains in the same cycle.
- Registers of a stalled stage hold their values. out_valid, y, out_tag and ovf stay stable while out_valid && !out_ready.
- Arithmetic: y = x1 + (x2 with bit 31 inverted).
- Exponent 0 means zero; denormal mantissas are flushed. Effective exponent is 1, mantissa 0.
- No NaN/inf input handling: exponent 255 is treated as an ordinary exponent.
- S1 (align):
  - Mantissas are extended to 25 bits as {01,m}.
  - Exponent difference de saturates at 31.
  - Operand order: larger exponent first; when exponents are equal, larger mantissa first. On an exact tie, x1 is the larger.
  - Result sign = sign of the larger operand.
  - Smaller mantissa is shifted right by de into a 27-bit field: mantissa plus 2 guard bits. Bits beyond the guard bits are dropped; there is no sticky bit.
- S2: {ms,2'b00} +/- aligned mi, 27 bits. Add when effective signs match, subtract otherwise.
- S3 (normalize/pack):
  - On carry-out (bit 26), shift right 1 and increment the exponent.
  - Otherwise use a leading-one count se (0..26) and shift left.
  - Underflow: if the exponent is not greater than se, the exponent becomes 0, the mantissa is shifted left by (exp-1) and the result is flushed to exponent 0.
  - Rounding is truncation: the result mantissa is bits [24:2].
  - Overflow: if the exponent reaches 255, y = {sign, 8'hFF, 23'b0} and ovf=1.
  - Exact-zero result: y = 32'h00000000, positive zero, ovf=0.
- The tag passes through unchanged, aligned with its result.

Test Plan:
- x1=0x40400000 (3.0), x2=0x3F800000 (1.0), tag=3, out_ready=1 -> 3 cycles later out_valid=1, y=0x40000000, out_tag=3, ovf=0.
- x1=x2=0x3F800000 -> y=0x00000000 (positive zero). Also 1.0 - (-1.0), x2=0xBF800000 -> y=0x40000000.
- x1=0x3F800000, x2=0x33800000 (2^-24) -> y=0x3F7FFFFF. With x2=0x30800000 (2^-30) -> y=0x3F800000 (truncation, no sticky).
- x1=0x7F7FFFFF, x2=0xFF7FFFFF -> y=0x7F800000, ovf=1. With x2=0x7F7FFFFF -> y=0, ovf=0.
- out_ready=0, present 4 back-to-back ops (tags 0-3):
  - tags 0-2 are accepted; in_ready drops after the third.
  - Tag 0 is held stable on the output.
  - Raise out_ready: results arrive in order 0,1,2,3 on consecutive cycles, and tag 3 is accepted in the same cycle tag 0 drains.
- Streaming 10 ops with out_ready=1 -> one result per cycle, no bubbles. Assert rst mid-stream -> out_valid=0 immediately; after release no stale results appear and the next op completes in 3 cycles.
